// File: rtl/mem_arb_pkg.sv
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and default widths for the IF/MEM memory port
//                arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2
    } arb_state_e;

    // Default port widths
    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
//  Module      : sat_counter
//  Description : CNT_W-wide up-counter that sticks at all-ones.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Increment unless already saturated
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Serialises instruction-fetch and load/store requests onto a
//                single-port memory and stalls the pipeline until every
//                request of the current pipeline cycle has completed.
//                Optional macro ARB_PERF_CNT_EN adds saturating stall and
//                conflict counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
`ifdef ARB_PERF_CNT_EN
    ,
    parameter int CNT_W  = 32
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              dm_read_i,
    input  logic              dm_write_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  conflict_cnt_o
`endif
);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_done_q, if_done_d;
    logic              dm_done_q, dm_done_d;

    logic              dm_req;
    logic              dm_pend;
    logic              if_pend;

    assign dm_req  = dm_read_i | dm_write_i;
    assign dm_pend = dm_req & ~dm_done_q;
    assign if_pend = if_req_i & ~if_done_q;
    assign stall_o = dm_pend | if_pend;

    // Next-state, memory command and capture logic; data wins over fetch
    // because the MEM-stage instruction is the older one
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_done_d  = if_done_q;
        dm_done_d  = dm_done_q;

        // Pipeline advances on this edge: start a fresh pipeline cycle
        if (!stall_o) begin
            if_done_d = 1'b0;
            dm_done_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (dm_pend) begin
                    state_d = DATA;
                    addr_d  = dm_addr_i;
                    wdata_d = dm_wdata_i;
                    we_d    = dm_write_i;
                end else if (if_pend) begin
                    state_d = FETCH;
                    addr_d  = if_addr_i;
                    we_d    = 1'b0;
                end
            end
            DATA: begin
                if (mem_ack_i) begin
                    if (!we_q) begin
                        dm_rdata_d = mem_rdata_i;
                    end
                    dm_done_d = 1'b1;
                    if (if_pend) begin
                        state_d = FETCH;
                        addr_d  = if_addr_i;
                        we_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        we_d    = 1'b0;
                    end
                end
            end
            FETCH: begin
                if (mem_ack_i) begin
                    if_rdata_d = mem_rdata_i;
                    if_done_d  = 1'b1;
                    if (dm_pend) begin
                        state_d = DATA;
                        addr_d  = dm_addr_i;
                        wdata_d = dm_wdata_i;
                        we_d    = dm_write_i;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                we_d    = 1'b0;
            end
        endcase
    end

    // State, memory command and captured-data registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_done_q  <= 1'b0;
            dm_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_done_q  <= if_done_d;
            dm_done_q  <= dm_done_d;
        end
    end

    assign mem_req_o   = (state_q != IDLE);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;

`ifdef ARB_PERF_CNT_EN
    logic conflict_inc;

    // A conflict is an IDLE cycle where both requesters still need service
    assign conflict_inc = (state_q == IDLE) & dm_pend & if_pend;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (stall_o),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_conflict_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (conflict_inc),
        .cnt_o (conflict_cnt_o)
    );
`endif

endmodule

`default_nettype wire
